md_sched: RTL and testbench

//  Sequences the multiply/divide unit (XALU) and owns the HI/LO registers for the MIPS pipeline.

---
 rtl/md_sched_pkg.sv | 35 +++
 rtl/md_sched_arith.sv | 69 ++++++
 rtl/md_sched.sv | 139 +++++++++++++
 tb/tb_md_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: XALU op codes,
// FSM state encoding and small op-classification helpers.
package md_sched_pkg;

  localparam logic [3:0] XOP_NONE  = 4'd0;
  localparam logic [3:0] XOP_MULT  = 4'd1;
  localparam logic [3:0] XOP_MULTU = 4'd2;
  localparam logic [3:0] XOP_MTHI  = 4'd3;
  localparam logic [3:0] XOP_MTLO  = 4'd4;
  localparam logic [3:0] XOP_MFHI  = 4'd5;
  localparam logic [3:0] XOP_MFLO  = 4'd6;
  localparam logic [3:0] XOP_DIV   = 4'd7;
  localparam logic [3:0] XOP_DIVU  = 4'd8;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  // Ops that occupy the unit for multiple cycles.
  function automatic logic is_long_op(input logic [3:0] op);
    return (op == XOP_MULT) || (op == XOP_MULTU) ||
           (op == XOP_DIV)  || (op == XOP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == XOP_DIV) || (op == XOP_DIVU);
  endfunction

  // Any op that touches HI/LO (codes 1..8).
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= XOP_MULT) && (op <= XOP_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_arith.sv
// Combinational mult/multu/div/divu datapath producing {hi,lo}.
// Division by zero raises div_zero; the quotient/remainder are then don't-care.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic [31:0] b_nz;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] q_u;
  logic [31:0] r_u;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Substitute a divisor of 1 so the divider never sees zero.
  assign b_zero = (b == 32'd0);
  assign b_nz   = b_zero ? 32'd1 : b;

  // Signed divide through magnitudes: truncation toward zero, remainder takes
  // the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign a_mag = a[31]    ? (32'd0 - a)    : a;
  assign b_mag = b_nz[31] ? (32'd0 - b_nz) : b_nz;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign q_s   = (a[31] ^ b_nz[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s   = a[31] ? (32'd0 - r_mag) : r_mag;

  assign q_u = a / b_nz;
  assign r_u = a % b_nz;

  // Select the result for the requested op.
  always_comb begin
    hi       = 32'd0;
    lo       = 32'd0;
    div_zero = 1'b0;
    case (op)
      XOP_MULT:  {hi, lo} = prod_s;
      XOP_MULTU: {hi, lo} = prod_u;
      XOP_DIV: begin
        lo       = q_s;
        hi       = r_s;
        div_zero = b_zero;
      end
      XOP_DIVU: begin
        lo       = q_u;
        hi       = r_u;
        div_zero = b_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide scheduler: owns HI/LO, emulates fixed mult/div latency
// with a down-counter, and requests a D-stage stall while an op is in flight.
//
//  state  | meaning
//  S_IDLE | unit free; mthi/mtlo write directly, mult/div may start
//  S_RUN  | op in flight; cnt counts down, commit of pending HI/LO at cnt==0
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_E,
  input  logic [3:0]  XALUOp_E,
  input  logic [3:0]  XALUOp_D,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_lo_q;
  logic             pend_wr_q;
  logic [31:0]      hi_q, lo_q;
  logic             commit;
  logic             wr_hi, wr_lo;

  logic [31:0] ar_hi, ar_lo;
  logic        ar_div_zero;

  md_arith u_arith (
    .op       (XALUOp_E),
    .a        (A),
    .b        (B),
    .hi       (ar_hi),
    .lo       (ar_lo),
    .div_zero (ar_div_zero)
  );

  assign busy     = (state_q == S_RUN);
  assign start    = issue_E & is_long_op(XALUOp_E) & ~busy;
  assign stall_md = (busy | start) & is_hilo_op(XALUOp_D);

  // Direct moves only land while the unit is idle.
  assign wr_hi = issue_E & ~busy & (XALUOp_E == XOP_MTHI);
  assign wr_lo = issue_E & ~busy & (XALUOp_E == XOP_MTLO);

  assign HI = hi_q;
  assign LO = lo_q;

  // Read mux for mfhi/mflo: architectural values only, never pending ones.
  always_comb begin
    rd_data = 32'd0;
    if (XALUOp_E == XOP_MFHI)      rd_data = hi_q;
    else if (XALUOp_E == XOP_MFLO) rd_data = lo_q;
  end

  // Next-state and latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = is_div_op(XALUOp_E) ? CNT_W'(DIV_CYCLES - 1)
                                        : CNT_W'(MULT_CYCLES - 1);
        end
      end
      S_RUN: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register and counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the result at start; a divide by zero suppresses the later commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else if (start) begin
      pend_hi_q <= ar_hi;
      pend_lo_q <= ar_lo;
      pend_wr_q <= ~(is_div_op(XALUOp_E) & ar_div_zero);
    end
  end

  // HI/LO update: commit has priority over a same-cycle move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (commit) begin
      if (pend_wr_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end else begin
      if (wr_hi) hi_q <= A;
      if (wr_lo) lo_q <= A;
    end
  end

  // An op reaching E while busy means the pipeline failed to stall.
  always_ff @(posedge clk) begin
    if (reset_n) assert (!(busy && issue_E && is_hilo_op(XALUOp_E)));
  end

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

  logic        clk;
  logic        reset_n;
  logic        issue_E;
  logic [3:0]  XALUOp_E;
  logic [3:0]  XALUOp_D;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  int vectors;
  int miscompares;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .issue_E  (issue_E),
    .XALUOp_E (XALUOp_E),
    .XALUOp_D (XALUOp_D),
    .A        (A),
    .B        (B),
    .start    (start),
    .busy     (busy),
    .stall_md (stall_md),
    .HI       (HI),
    .LO       (LO),
    .rd_data  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    issue_E  = 1'b1;
    XALUOp_E = op;
    A        = a;
    B        = b;
    #1;
  endtask

  // Runs n busy cycles, dropping issue after the start edge; HI/LO must hold.
  task automatic run_busy(input int n, input logic [31:0] hi_hold,
                          input logic [31:0] lo_hold, input logic stall_exp);
    for (int i = 0; i < n; i++) begin
      tick();
      issue_E  = 1'b0;
      XALUOp_E = 4'd0;
      #1;
      chk($sformatf("busy_c%0d", i + 1), {31'd0, busy}, 32'd1);
      chk($sformatf("hi_hold_c%0d", i + 1), HI, hi_hold);
      chk($sformatf("lo_hold_c%0d", i + 1), LO, lo_hold);
      chk($sformatf("stall_c%0d", i + 1), {31'd0, stall_md}, {31'd0, stall_exp});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n  = 1'b0;
    issue_E  = 1'b0;
    XALUOp_E = 4'd0;
    XALUOp_D = 4'd0;
    A        = 32'd0;
    B        = 32'd0;
    tick();
    tick();
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_hi",    HI, 32'd0);
    chk("rst_lo",    LO, 32'd0);
    chk("rst_start", {31'd0, start}, 32'd0);
    reset_n = 1'b1;
    tick();

    // mult -3 * 7 = -21
    issue(4'd1, 32'hFFFF_FFFD, 32'd7);
    chk("mult_start", {31'd0, start}, 32'd1);
    chk("mult_nostall", {31'd0, stall_md}, 32'd0);
    run_busy(5, 32'd0, 32'd0, 1'b0);
    tick();
    chk("mult_busy_done", {31'd0, busy}, 32'd0);
    chk("mult_hi", HI, 32'hFFFF_FFFF);
    chk("mult_lo", LO, 32'hFFFF_FFEB);

    // multu 0xFFFFFFFF * 2 with mflo waiting in D
    XALUOp_D = 4'd6;
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    chk("multu_start", {31'd0, start}, 32'd1);
    chk("multu_stall_start", {31'd0, stall_md}, 32'd1);
    run_busy(5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b1);
    tick();
    chk("multu_stall_drop", {31'd0, stall_md}, 32'd0);
    chk("multu_busy_done", {31'd0, busy}, 32'd0);
    chk("multu_hi", HI, 32'd1);
    chk("multu_lo", LO, 32'hFFFF_FFFE);
    XALUOp_D = 4'd0;

    // div -7 / 2 = -3 rem -1
    issue(4'd7, 32'hFFFF_FFF9, 32'd2);
    chk("div_start", {31'd0, start}, 32'd1);
    run_busy(10, 32'd1, 32'hFFFF_FFFE, 1'b0);
    tick();
    chk("div_busy_done", {31'd0, busy}, 32'd0);
    chk("div_hi", HI, 32'hFFFF_FFFF);
    chk("div_lo", LO, 32'hFFFF_FFFD);

    // divu 7 / 0: full latency, HI/LO untouched
    issue(4'd8, 32'd7, 32'd0);
    chk("divu0_start", {31'd0, start}, 32'd1);
    run_busy(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();
    chk("divu0_busy_done", {31'd0, busy}, 32'd0);
    chk("divu0_hi", HI, 32'hFFFF_FFFF);
    chk("divu0_lo", LO, 32'hFFFF_FFFD);

    // div overflow case
    issue(4'd7, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    tick();
    chk("divovf_hi", HI, 32'd0);
    chk("divovf_lo", LO, 32'h8000_0000);

    // mthi, then reads
    issue(4'd3, 32'h0000_1234, 32'd0);
    chk("mthi_nostart", {31'd0, start}, 32'd0);
    tick();
    chk("mthi_hi", HI, 32'h0000_1234);
    chk("mthi_lo_kept", LO, 32'h8000_0000);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    issue(4'd5, 32'd0, 32'd0);
    chk("mfhi_rd", rd_data, 32'h0000_1234);
    issue(4'd6, 32'd0, 32'd0);
    chk("mflo_rd", rd_data, 32'h8000_0000);
    issue(4'd0, 32'd0, 32'd0);
    chk("none_rd", rd_data, 32'd0);

    // mtlo
    issue(4'd4, 32'h0000_0055, 32'd0);
    tick();
    chk("mtlo_lo", LO, 32'h0000_0055);
    chk("mtlo_hi_kept", HI, 32'h0000_1234);

    // unknown op: nothing happens
    issue(4'd9, 32'hDEAD_BEEF, 32'd1);
    chk("unk_start", {31'd0, start}, 32'd0);
    tick();
    chk("unk_busy", {31'd0, busy}, 32'd0);
    chk("unk_hi", HI, 32'h0000_1234);
    chk("unk_lo", LO, 32'h0000_0055);

    // reset during busy cycle 3 of a div
    issue(4'd7, 32'd100, 32'd3);
    run_busy(3, 32'h0000_1234, 32'h0000_0055, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", HI, 32'd0);
    chk("abort_lo", LO, 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("abort_nocommit_hi", HI, 32'd0);
    chk("abort_nocommit_lo", LO, 32'd0);
    chk("abort_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
